// File: rtl/cpu_clk_seq_pkg.sv
// Shared definitions for the cpu_clk_sequencer slice.
//   seq_state_t : FSM state encoding (HALT=0, RUN=1, STEP=2), also the
//                 value driven on the sequencer's 2-bit state output.
//   DIV_W_DEF   : default width of the CPU divisor and its counter.
//   BKPT_W_DEF  : default width of the breakpoint enable counter.
package cpu_clk_seq_pkg;

    localparam int unsigned DIV_W_DEF  = 26;
    localparam int unsigned BKPT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cpu_clk_sequencer_prescaler.sv
// tick_prescaler: modulo-N event counter.
//   Counts 0..N-1 on cycles where en=1. tick is high in the en cycle in which
//   the count is at N-1, i.e. the cycle it wraps back to 0. Because tick is
//   qualified by en, a cascaded instance fed by another instance's tick
//   produces a pulse coincident with that input tick.
// Ports:
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset, clears the count
//   en    in  1  count enable
//   tick  out 1  single-cycle wrap pulse
module tick_prescaler #(
    parameter int unsigned N = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(N - 1));
    assign tick = en && wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_clk_sequencer.sv
// cpu_clk_sequencer: clock-enable scheduler for the FPSM CPU and its slow
// peripherals. Everything runs on clk; only single-cycle enables leave.
//   clk, rst_n          clock, asynchronous active-low reset
//   run_req, halt_req   level requests (priority halt > step > run)
//   step_req            pulse; one CPU enable while halted
//   div_wr, div_val     write strobe and value for the CPU divisor (0 acts as 1)
//   cpu_ce              CPU clock enable, period max(div,1) in RUN
//   tick_1khz           pulse every CLK_HZ/1000 clocks, free-running
//   tick_100hz          pulse on every SLOW_DIV-th tick_1khz, coincident
//   state               0=HALT 1=RUN 2=STEP
//   step_done           pulse in the cycle after a step's cpu_ce
// Optional feature macro CPU_CLK_SEQ_BKPT_EN adds parameter BKPT_W and ports
//   bkpt_val, bkpt_arm (in) and bkpt_hit (out): an armed breakpoint that
//   halts RUN after exactly bkpt_val enables.
module cpu_clk_sequencer
    import cpu_clk_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned CPU_DIV_RST = 33_554_432,
    parameter int unsigned SLOW_DIV    = 10
`ifdef CPU_CLK_SEQ_BKPT_EN
    ,
    parameter int unsigned BKPT_W      = BKPT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_val,
`ifdef CPU_CLK_SEQ_BKPT_EN
    input  logic [BKPT_W-1:0] bkpt_val,
    input  logic              bkpt_arm,
    output logic              bkpt_hit,
`endif
    output logic             cpu_ce,
    output logic             tick_1khz,
    output logic             tick_100hz,
    output logic [1:0]       state,
    output logic             step_done
);

    localparam int unsigned KHZ_DIV = CLK_HZ / 1000;

    seq_state_t       st_q, st_d;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload;
    logic             run_ce;
    logic             bkpt_stop;
    logic             start_q;

    // ---------------- slow prescaler ----------------
    // start_q holds the 1 kHz counter for the first cycle after reset so the
    // first tick lands exactly KHZ_DIV clocks after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b1;
        end
    end

    tick_prescaler #(.N(KHZ_DIV)) u_khz (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (start_q),
        .tick  (tick_1khz)
    );

    tick_prescaler #(.N(SLOW_DIV)) u_slow (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_1khz),
        .tick  (tick_100hz)
    );

    // ---------------- CPU divider ----------------
    assign reload = (div_reg == '0) ? '0 : div_reg - 1'b1;
    assign run_ce = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= DIV_W'(CPU_DIV_RST);
        end else if (div_wr) begin
            div_reg <= div_val;
        end
    end

    // Outside RUN the counter tracks the reload value, so entering RUN gives a
    // full period before the first enable; in RUN a divisor write only takes
    // effect at the next reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (st_q == ST_RUN && !run_ce) begin
            cnt <= cnt - 1'b1;
        end else begin
            cnt <= reload;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= ST_HALT;
            step_done <= 1'b0;
        end else begin
            st_q      <= st_d;
            step_done <= (st_q == ST_STEP);
        end
    end

    always_comb begin
        st_d   = st_q;
        cpu_ce = 1'b0;
        case (st_q)
            ST_HALT: begin
                if (halt_req) begin
                    st_d = ST_HALT;
                end else if (step_req) begin
                    st_d = ST_STEP;
                end else if (run_req) begin
                    st_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cpu_ce = run_ce;
                if (halt_req || bkpt_stop) begin
                    st_d = ST_HALT;
                end
            end
            ST_STEP: begin
                cpu_ce = 1'b1;
                st_d   = ST_HALT;
            end
            default: begin
                st_d = ST_HALT;
            end
        endcase
    end

    assign state = st_q;

    // ---------------- breakpoint ----------------
`ifdef CPU_CLK_SEQ_BKPT_EN
    logic [BKPT_W-1:0] ce_cnt;
    logic              arm_q;
    logic              arm_rise;

    assign arm_rise = bkpt_arm && !arm_q;

    // Stop on the enable that brings the count to bkpt_val, so that enable is
    // the last one issued.
    assign bkpt_stop = bkpt_arm && !arm_rise && (st_q == ST_RUN) && run_ce &&
                       ((ce_cnt + 1'b1) == bkpt_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_cnt   <= '0;
            arm_q    <= 1'b0;
            bkpt_hit <= 1'b0;
        end else begin
            arm_q    <= bkpt_arm;
            bkpt_hit <= bkpt_stop;
            if (arm_rise) begin
                ce_cnt <= '0;
            end else if (cpu_ce) begin
                ce_cnt <= ce_cnt + 1'b1;
            end
        end
    end
`else
    assign bkpt_stop = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_clk_sequencer.sv
module tb_cpu_clk_sequencer;

    localparam int unsigned DIV_W = 26;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run_req = 1'b0;
    logic             halt_req = 1'b0;
    logic             step_req = 1'b0;
    logic             div_wr = 1'b0;
    logic [DIV_W-1:0] div_val = '0;
    logic             cpu_ce;
    logic             tick_1khz;
    logic             tick_100hz;
    logic [1:0]       state;
    logic             step_done;
`ifdef CPU_CLK_SEQ_BKPT_EN
    logic [15:0]      bkpt_val = '0;
    logic             bkpt_arm = 1'b0;
    logic             bkpt_hit;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_clk_sequencer #(
        .CLK_HZ      (10_000),
        .DIV_W       (DIV_W),
        .CPU_DIV_RST (33_554_432),
        .SLOW_DIV    (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .div_wr     (div_wr),
        .div_val    (div_val),
`ifdef CPU_CLK_SEQ_BKPT_EN
        .bkpt_val   (bkpt_val),
        .bkpt_arm   (bkpt_arm),
        .bkpt_hit   (bkpt_hit),
`endif
        .cpu_ce     (cpu_ce),
        .tick_1khz  (tick_1khz),
        .tick_100hz (tick_100hz),
        .state      (state),
        .step_done  (step_done)
    );

    typedef struct {
        logic             rst;
        logic             run;
        logic             halt;
        logic             step;
        logic             wr;
        logic [DIV_W-1:0] val;
        logic             ce;
        logic [1:0]       st;
        logic             done;
    } vec_t;

    typedef struct {
        logic       ce;
        logic [1:0] st;
        logic       done;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t v(input logic rst, input logic run, input logic halt,
                               input logic step, input logic wr, input logic [DIV_W-1:0] val,
                               input logic ce, input logic [1:0] st, input logic done);
        vec_t r;
        r.rst = rst; r.run = run; r.halt = halt; r.step = step; r.wr = wr; r.val = val;
        r.ce = ce; r.st = st; r.done = done;
        return r;
    endfunction

    task automatic idle_inputs();
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; div_wr = 1'b0; div_val = '0;
    endtask

    initial begin
        exp_t  e;
        bit    found;
        int    ce_n;
        int    hit_n;

        // ---- rows: rst run halt step wr val | ce st done ----
        // divisor 4 then 2 written mid-period
        vecs.push_back(v(1, 0, 0, 0, 1, 4, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 2, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0));
        // three steps 5 clocks apart
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(v(0, 0, 0, 1, 0, 0, 1, 2, 0));
            vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));
            vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
            vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
            vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        // run at div 2, step ignored in RUN, halt on a ce cycle, step+run in HALT
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 0, 0, 1, 2, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0));
        // divisor 0 then 1: continuous enables
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 1, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));

        // ---- reset state and prescaler ----
        #2;
        check("rst_ce", cpu_ce, 0);
        check("rst_1k", tick_1khz, 0);
        check("rst_100", tick_100hz, 0);
        check("rst_state", state, 0);
        check("rst_done", step_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("tick1k_clk%0d", k), tick_1khz, (k % 10 == 0) ? 1 : 0);
            check($sformatf("tick100_clk%0d", k), tick_100hz, (k == 100) ? 1 : 0);
        end

        // ---- table-driven vectors through the scoreboard ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].rst) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            run_req  = vecs[i].run;
            halt_req = vecs[i].halt;
            step_req = vecs[i].step;
            div_wr   = vecs[i].wr;
            div_val  = vecs[i].val;
            e.ce = vecs[i].ce; e.st = vecs[i].st; e.done = vecs[i].done;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            check($sformatf("row%0d_ce", i), cpu_ce, e.ce);
            check($sformatf("row%0d_state", i), state, e.st);
            check($sformatf("row%0d_done", i), step_done, e.done);
        end

        // ---- asynchronous reset mid-run (div 1, RUN) ----
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_ce", cpu_ce, 0);
        check("async_rst_state", state, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_ce%0d", k), cpu_ce, 0);
            check($sformatf("post_rst_state%0d", k), state, 0);
        end

        // ---- reset aborts a pending step ----
        @(negedge clk);
        step_req = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        step_req = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_step_ce%0d", k), cpu_ce, 0);
            check($sformatf("abort_step_done%0d", k), step_done, 0);
        end

        // ---- halt raised during a ce cycle, divisor 3 ----
        @(negedge clk);
        div_wr = 1'b1; div_val = 3;
        @(negedge clk);
        div_wr = 1'b0;
        @(negedge clk);
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk);
            #1;
            if (cpu_ce) found = 1'b1;
        end
        check("ce_seen_before_halt", found, 1);
        @(negedge clk);
        halt_req = 1'b1;
        #1;
        check("ce_with_halt", cpu_ce, 1);
        @(posedge clk);
        #1;
        check("halted_state", state, 0);
        @(negedge clk);
        halt_req = 1'b0;
        ce_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (cpu_ce) ce_n++;
        end
        check("no_ce_after_halt", ce_n, 0);

`ifdef CPU_CLK_SEQ_BKPT_EN
        // ---- breakpoint: exactly 5 enables at divisor 3 ----
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        div_wr = 1'b1; div_val = 3;
        bkpt_val = 16'd5;
        @(negedge clk);
        div_wr = 1'b0;
        bkpt_arm = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        ce_n = 0;
        hit_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (cpu_ce) ce_n++;
            if (bkpt_hit) hit_n++;
        end
        check("bkpt_ce_count", ce_n, 5);
        check("bkpt_hit_count", hit_n, 1);
        check("bkpt_state", state, 0);
        bkpt_arm = 1'b0;
`else
        hit_n = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
